calc_ctrl: RTL and testbench

Parametrised main controller for the keypad calculator. It consumes single-cycle key events already synchronised to `clk`, builds two BCD operands by digit entry, and drives a multi-cycle ALU through a start/done handshake. It supports operation chaining, distinguishes clear-entry from clear-all, and has an error state. It sits between the keypad scanner and the ALU/display driver and replaces the single-width, edge-triggered controller.

---
 rtl/calc_pkg.sv | 16 +
 rtl/calc_operand_entry.sv | 49 ++++
 rtl/calc_ctrl.sv | 142 ++++++++++++++
 tb/tb_calc_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, FSM state encoding and display constants shared by the calculator controller.
package calc_pkg;
  localparam logic [3:0] KEY_DIG_MAX = 4'd9;
  localparam logic [3:0] KEY_EQ      = 4'hA;
  localparam logic [3:0] KEY_AC      = 4'hB;
  localparam logic [3:0] KEY_OP_MIN  = 4'hC;
  localparam logic [2:0] ST_ENTER_A  = 3'd0;
  localparam logic [2:0] ST_ENTER_B  = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_SHOW_RES = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;
  localparam logic [3:0] ERR_NIB     = 4'hE;
  function automatic int ndig(input int width);
    return width / 4;
  endfunction
endpackage

// File: rtl/calc_operand_entry.sv
// calc_operand_entry: one BCD operand register built by shifting in digits, with clear and parallel load.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(ndig(WIDTH) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [3:0]       digit_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] val_o,
  output logic [CW-1:0]    cnt_o,
  output logic             full_o
);
  localparam logic [CW-1:0] NFULL = CW'(ndig(WIDTH));
  logic [WIDTH-1:0] val_q, val_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  assign val_o  = val_q;
  assign cnt_o  = cnt_q;
  assign full_o = cnt_q == NFULL;
  // clear together with shift starts a fresh entry holding that one digit
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      val_d = shift_i ? WIDTH'(digit_i) : '0;
      cnt_d = shift_i ? CW'(1) : '0;
    end else if (load_i) begin
      val_d = load_val_i;
      cnt_d = '0;
    end else if (shift_i && !full_o && (val_q != '0 || digit_i != 4'd0)) begin
      val_d = {val_q[WIDTH-5:0], digit_i};
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator controller; builds BCD operands, chains operations and drives a start/done ALU.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] display,
  output logic [2:0]       state,
  output logic             err
);
  localparam int NDIG = ndig(WIDTH);
  localparam int CW   = $clog2(NDIG + 1);
  localparam int TW   = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ALU_TIMEOUT);
  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d, pend_q, pend_d;
  logic             ret_b_q, ret_b_d, start_q, start_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] hold_q, a_val, b_val, live;
  logic [CW-1:0]    a_cnt_unused, b_cnt;
  logic             a_full, b_full;
  logic             a_sh, a_clr, a_ld, b_sh, b_clr;
  logic             is_dig, is_eq, is_ac, is_op;
  assign is_dig = key_code <= KEY_DIG_MAX;
  assign is_eq  = key_code == KEY_EQ;
  assign is_ac  = key_code == KEY_AC;
  assign is_op  = key_code >= KEY_OP_MIN;
  calc_operand_entry #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .reset(reset), .shift_i(a_sh), .clr_i(a_clr), .load_i(a_ld), .digit_i(key_code),
    .load_val_i(alu_result), .val_o(a_val), .cnt_o(a_cnt_unused), .full_o(a_full)
  );
  calc_operand_entry #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .reset(reset), .shift_i(b_sh), .clr_i(b_clr), .load_i(1'b0), .digit_i(key_code),
    .load_val_i('0), .val_o(b_val), .cnt_o(b_cnt), .full_o(b_full)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pend_d  = pend_q;
    ret_b_d = ret_b_q;
    start_d = 1'b0;
    tmo_d   = state_q == ST_WAIT ? tmo_q + 1'b1 : '0;
    a_sh    = 1'b0;
    a_clr   = 1'b0;
    a_ld    = 1'b0;
    b_sh    = 1'b0;
    b_clr   = 1'b0;
    case (state_q)
      ST_ENTER_A: if (key_valid) begin
        a_sh  = is_dig && !a_full;
        a_clr = is_ac;
        b_clr = is_op;
        op_d    = is_op ? key_code : op_q;
        state_d = is_op ? ST_ENTER_B : ST_ENTER_A;
      end
      ST_ENTER_B: if (key_valid) begin
        b_sh = is_dig && !b_full;
        // an operator after B digits chains: run the old op now, apply the new one on return
        if (is_eq || (is_op && b_cnt != '0)) begin
          start_d = 1'b1;
          state_d = ST_WAIT;
          ret_b_d = is_op;
          pend_d  = key_code;
        end else if (is_op) begin
          op_d = key_code;
        end else if (is_ac) begin
          b_clr   = 1'b1;
          a_clr   = b_cnt == '0;
          state_d = b_cnt == '0 ? ST_ENTER_A : ST_ENTER_B;
        end
      end
      ST_WAIT: begin
        // a done coincident with start belongs to no operation of ours
        if (alu_done && !start_q) begin
          state_d = alu_err ? ST_ERROR : ret_b_q ? ST_ENTER_B : ST_SHOW_RES;
          a_ld    = !alu_err;
          b_clr   = !alu_err && ret_b_q;
          op_d    = !alu_err && ret_b_q ? pend_q : op_q;
        end else if (tmo_q == TMAX) begin
          state_d = ST_ERROR;
        end
      end
      ST_SHOW_RES: if (key_valid) begin
        a_clr   = is_dig || is_ac;
        a_sh    = is_dig;
        b_clr   = !is_eq;
        start_d = is_eq;
        ret_b_d = 1'b0;
        op_d    = is_op ? key_code : op_q;
        state_d = is_eq ? ST_WAIT : is_op ? ST_ENTER_B : ST_ENTER_A;
      end
      ST_ERROR: if (key_valid && is_ac) begin
        a_clr   = 1'b1;
        b_clr   = 1'b1;
        state_d = ST_ENTER_A;
      end
      default: state_d = ST_ENTER_A;
    endcase
  end
  assign live = state_q == ST_ERROR ? {NDIG{ERR_NIB}} :
                state_q == ST_ENTER_B ? (b_cnt == '0 ? WIDTH'(op_q) : b_val) : a_val;
  assign display   = state_q == ST_WAIT ? hold_q : live;
  assign key_busy  = state_q == ST_WAIT;
  assign err       = state_q == ST_ERROR;
  assign state     = state_q;
  assign alu_a     = a_val;
  assign alu_b     = b_val;
  assign alu_op    = op_q;
  assign alu_start = start_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ENTER_A;
      op_q    <= '0;
      pend_q  <= '0;
      ret_b_q <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      ret_b_q <= ret_b_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      hold_q  <= display;
    end
  end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed and random key sequences checked against a key-level calculator model.
module tb_calc_ctrl;
  localparam int W = 16;
  localparam int T = 64;
  localparam int MA = 0, MB = 1, MW = 2, MS = 3, ME = 4;
  logic clk = 0, reset = 1, key_valid = 0, alu_done = 0, alu_err = 0;
  logic [3:0] key_code = 0;
  logic [W-1:0] alu_result = 0;
  logic key_busy, alu_start, err;
  logic [W-1:0] alu_a, alu_b, display;
  logic [3:0] alu_op;
  logic [2:0] state;
  int checks = 0, errors = 0;
  int m_st, na, nb;
  logic [W-1:0] ma, mb, mhold, ea, eb;
  logic [3:0] mop, mpend, eop;
  bit mret_b;

  calc_ctrl #(.WIDTH(W), .ALU_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .key_busy(key_busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .alu_err(alu_err), .display(display), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_disp();
    case (m_st)
      MA, MS:  return ma;
      MB:      return nb == 0 ? {12'h000, mop} : mb;
      ME:      return 16'hEEEE;
      default: return mhold;
    endcase
  endfunction

  task automatic enter(inout logic [W-1:0] x, inout int n, input logic [3:0] d);
    if (n < W / 4 && !(x == 0 && d == 0)) begin
      x = x * 16 + d;
      n++;
    end
  endtask

  task automatic model_clear();
    ma = 0; mb = 0; na = 0; nb = 0; m_st = MA;
  endtask

  task automatic model_key(input logic [3:0] k, output bit go);
    bit dig, op, eq, ac;
    dig = k <= 9; op = k >= 4'hC; eq = k == 4'hA; ac = k == 4'hB;
    go = 0;
    case (m_st)
      MA: if (dig) enter(ma, na, k);
          else if (op) begin mop = k; mb = 0; nb = 0; m_st = MB; end
          else if (ac) begin ma = 0; na = 0; end
      MB: if (dig) enter(mb, nb, k);
          else if (eq || (op && nb > 0)) begin go = 1; mret_b = op; if (op) mpend = k; end
          else if (op) mop = k;
          else if (ac) begin
            if (nb > 0) begin mb = 0; nb = 0; end
            else model_clear();
          end
      MS: if (dig) begin ma = {12'h000, k}; na = 1; mb = 0; nb = 0; m_st = MA; end
          else if (op) begin mop = k; mb = 0; nb = 0; m_st = MB; end
          else if (eq) begin go = 1; mret_b = 0; end
          else model_clear();
      ME: if (ac) model_clear();
      default: ;
    endcase
    if (go) begin
      mhold = exp_disp(); ea = ma; eb = mb; eop = mop; m_st = MW;
    end
  endtask

  task automatic model_done(input logic [W-1:0] res, input bit aerr);
    if (aerr) m_st = ME;
    else begin
      ma = res; na = 0;
      if (mret_b) begin mb = 0; nb = 0; mop = mpend; m_st = MB; end
      else m_st = MS;
    end
  endtask

  task automatic check_outs(input string t);
    check({t, "_state"}, 32'(state), m_st);
    check({t, "_disp"}, 32'(display), 32'(exp_disp()));
    check({t, "_err"}, 32'(err), 32'(m_st == ME));
    check({t, "_busy"}, 32'(key_busy), 32'(m_st == MW));
  endtask

  task automatic press(input logic [3:0] k);
    bit go;
    key_valid = 1; key_code = k;
    @(negedge clk);
    key_valid = 0;
    model_key(k, go);
    check_outs("key");
    check("start", 32'(alu_start), 32'(go));
    if (go) begin
      check("alu_a", 32'(alu_a), 32'(ea));
      check("alu_b", 32'(alu_b), 32'(eb));
      check("alu_op", 32'(alu_op), 32'(eop));
    end
  endtask

  task automatic run_alu(input int lat, input logic [W-1:0] res, input bit aerr, input bit early);
    if (early) begin alu_done = 1; alu_err = 1; alu_result = '1; end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      alu_done = 0; alu_err = 0;
      key_valid = 1'($urandom_range(0, 1)); key_code = 4'($urandom);
      check("wait_state", 32'(state), MW);
      check("wait_busy", 32'(key_busy), 1);
      check("wait_start", 32'(alu_start), 0);
    end
    @(negedge clk);
    key_valid = 0; alu_done = 1; alu_result = res; alu_err = aerr;
    check("done_busy", 32'(key_busy), 1);
    check("hold_a", 32'(alu_a), 32'(ea));
    check("hold_b", 32'(alu_b), 32'(eb));
    @(negedge clk);
    alu_done = 0; alu_err = 0;
    model_done(res, aerr);
    check_outs("done");
  endtask

  task automatic stall();
    for (int i = 1; i <= T; i++) begin
      @(negedge clk);
      key_valid = i == 2; key_code = 4'hB;
      check("stall_state", 32'(state), MW);
    end
    @(negedge clk);
    key_valid = 0;
    m_st = ME;
    check_outs("tmo");
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_clear(); mop = 0; mpend = 0; mret_b = 0; mhold = 0;
  endtask

  task automatic check_zero(input string t);
    check_outs(t);
    check({t, "_a"}, 32'(alu_a), 0);
    check({t, "_b"}, 32'(alu_b), 0);
    check({t, "_op"}, 32'(alu_op), 0);
    check({t, "_start"}, 32'(alu_start), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_zero("rst");
    // 1,2,+,3,4,= then = repeats with A=result
    press(1); press(2); press(4'hC); press(3); press(4); press(4'hA);
    check("tp1_a", 32'(alu_a), 32'h0012);
    check("tp1_b", 32'(alu_b), 32'h0034);
    check("tp1_op", 32'(alu_op), 32'hC);
    run_alu(3, 16'h0046, 0, 0);
    check("tp1_disp", 32'(display), 32'h0046);
    check("tp1_state", 32'(state), 3);
    press(4'hA);
    check("rep_a", 32'(alu_a), 32'h0046);
    run_alu(1, 16'h0080, 0, 1);
    // fifth digit ignored
    do_reset();
    press(1); press(2); press(3); press(4); press(5);
    check("tp2_a", 32'(display), 32'h1234);
    press(4'hB);
    check("tp2_ac", 32'(display), 0);
    // chained 9+2*3=
    do_reset();
    press(9); press(4'hC); press(2); press(4'hE);
    run_alu(2, 16'h0011, 0, 1);
    press(3); press(4'hA);
    check("tp3_a", 32'(alu_a), 32'h0011);
    check("tp3_op", 32'(alu_op), 32'hE);
    run_alu(4, 16'h0033, 0, 0);
    check("tp3_disp", 32'(display), 32'h0033);
    // divide by zero error
    do_reset();
    press(5); press(4'hF); press(0); press(4'hA);
    run_alu(2, 16'h0000, 1, 0);
    check("tp4_disp", 32'(display), 32'hEEEE);
    press(1); press(4'hC); press(4'hA); press(4'hB);
    check("tp4_clr", 32'(state), 0);
    // timeout, then done exactly at the limit
    press(1); press(4'hC); press(2); press(4'hA);
    stall();
    press(4'hB);
    press(1); press(4'hC); press(2); press(4'hA);
    run_alu(T, 16'h0099, 0, 0);
    check("edge_state", 32'(state), 3);
    // reset mid-ALU, late done ignored
    press(7); press(4'hC); press(3); press(4'hA);
    do_reset();
    check_zero("midrst");
    alu_done = 1; alu_result = 16'h1111;
    @(negedge clk);
    alu_done = 0;
    @(negedge clk);
    check_zero("late");
    // random sequences
    for (int n = 0; n < 400; n++) begin
      press(4'($urandom_range(0, 15)));
      if (m_st == MW)
        run_alu($urandom_range(1, 6), W'($urandom), ($urandom % 8) == 0, ($urandom % 4) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
